// File: rtl/ram_ctrl_pkg.sv
// Shared types and defaults for the RAM access arbiter: requester ids and
// the read-tag record that follows each read through the RAM latency.
package ram_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_RD_LAT     = 1;

    // Ids are sized for the largest supported requester count so the tag
    // type does not depend on a per-instance parameter.
    localparam int MAX_REQ  = 4;
    localparam int ID_WIDTH = $clog2(MAX_REQ);

    typedef logic [ID_WIDTH-1:0] req_id_t;

    typedef struct packed {
        logic    vld;
        req_id_t id;
    } rd_tag_t;

    function automatic req_id_t next_id(input req_id_t id, input int num_req);
        int n;
        n = int'(id) + 1;
        if (n >= num_req) begin
            n = 0;
        end
        return req_id_t'(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from the pointer with wrap-around,
// grants at most one requester per cycle and moves the pointer past the winner.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req,
    output logic [NUM_REQ-1:0]                gnt,
    output logic [ram_ctrl_pkg::ID_WIDTH-1:0] gnt_id,
    output logic                              gnt_any,
    output logic [ram_ctrl_pkg::ID_WIDTH-1:0] ptr_o
);
    import ram_ctrl_pkg::*;

    req_id_t ptr_q;
    req_id_t ptr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = next_id(gnt_id, NUM_REQ);
        end
    end

    // Distance k from the pointer is the priority; the first requesting
    // slot found at the smallest distance wins.
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        if (!rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!gnt_any && req[i] && (((int'(ptr_q) + k) % NUM_REQ) == i)) begin
                        gnt_any = 1'b1;
                        gnt[i]  = 1'b1;
                        gnt_id  = req_id_t'(i);
                    end
                end
            end
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares one single-port RAM between NUM_REQ requesters: one command per cycle,
// registered RAM strobes, and read data routed back to the issuing requester.
module ram_access_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = ram_ctrl_pkg::DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = ram_ctrl_pkg::DEF_DATA_WIDTH,
    parameter int RD_LAT     = ram_ctrl_pkg::DEF_RD_LAT
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ-1:0]                req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata,
    output logic [NUM_REQ-1:0]                gnt,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [DATA_WIDTH-1:0]             rsp_data,
    output logic                              wr_enb,
    output logic [ADDR_WIDTH-1:0]             wr_addr,
    output logic [DATA_WIDTH-1:0]             wr_data,
    output logic                              rd_enb,
    output logic [ADDR_WIDTH-1:0]             rd_addr,
    input  logic [DATA_WIDTH-1:0]             rd_data,
    output logic [ram_ctrl_pkg::ID_WIDTH-1:0] dbg_rr_ptr_o
);
    import ram_ctrl_pkg::*;

    req_id_t gnt_id;
    logic    gnt_any;

    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  issue_wr;
    logic                  issue_rd;

    logic                  wr_enb_q,  wr_enb_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  rd_enb_q,  rd_enb_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q,  rsp_data_d;

    // Stage 0 lines up with rd_enb, stage RD_LAT with valid rd_data.
    rd_tag_t tag_q [RD_LAT+1];
    rd_tag_t tag_d [RD_LAT+1];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_any (gnt_any),
        .ptr_o   (dbg_rr_ptr_o)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign issue_wr = gnt_any & sel_we;
    assign issue_rd = gnt_any & ~sel_we;

    // Address/data registers only load on their own command so idle cycles
    // leave the RAM bus parked on its last value.
    always_comb begin
        wr_enb_d  = issue_wr;
        wr_addr_d = issue_wr ? sel_addr  : wr_addr_q;
        wr_data_d = issue_wr ? sel_wdata : wr_data_q;
        rd_enb_d  = issue_rd;
        rd_addr_d = issue_rd ? sel_addr  : rd_addr_q;

        tag_d[0].vld = issue_rd;
        tag_d[0].id  = gnt_id;
        for (int k = 1; k <= RD_LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end

        rsp_valid_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (tag_q[RD_LAT].vld && (int'(tag_q[RD_LAT].id) == i)) begin
                rsp_valid_d[i] = 1'b1;
            end
        end
        rsp_data_d = tag_q[RD_LAT].vld ? rd_data : rsp_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_enb_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_enb_q    <= 1'b0;
            rd_addr_q   <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            for (int k = 0; k <= RD_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            wr_enb_q    <= wr_enb_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_enb_q    <= rd_enb_d;
            rd_addr_q   <= rd_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            for (int k = 0; k <= RD_LAT; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign wr_enb    = wr_enb_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign rd_enb    = rd_enb_q;
    assign rd_addr   = rd_addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

    a_strobes_exclusive : assert property (@(posedge clk) !(wr_enb_q && rd_enb_q));
    a_gnt_onehot0       : assert property (@(posedge clk) $onehot0(gnt));

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Bench for ram_access_arbiter: a behavioural RAM, a cycle model of the
// arbiter driving an expected-response queue, and per-scenario tasks.
module tb_ram_access_arbiter;
    import ram_ctrl_pkg::*;

    localparam int NR   = 2;
    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int RL   = 1;
    localparam int SB_W = 32 + NR + DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [NR-1:0]      req       = '0;
    logic [NR-1:0]      req_we    = '0;
    logic [NR*AW-1:0]   req_addr  = '0;
    logic [NR*DW-1:0]   req_wdata = '0;
    logic [NR-1:0]      gnt;
    logic [NR-1:0]      rsp_valid;
    logic [DW-1:0]      rsp_data;
    logic               wr_enb;
    logic [AW-1:0]      wr_addr;
    logic [DW-1:0]      wr_data;
    logic               rd_enb;
    logic [AW-1:0]      rd_addr;
    logic [DW-1:0]      rd_data = '0;
    logic [ID_WIDTH-1:0] dbg_rr_ptr;

    ram_access_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RD_LAT     (RL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .gnt          (gnt),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .wr_enb       (wr_enb),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_enb       (rd_enb),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .dbg_rr_ptr_o (dbg_rr_ptr)
    );

    // Single-port RAM with one cycle of read latency.
    logic [DW-1:0] ram [256];
    always @(posedge clk) begin
        if (wr_enb) ram[wr_addr] <= wr_data;
        if (rd_enb) rd_data <= ram[rd_addr];
    end

    // ---------------- reference model + scoreboard ----------------
    int             n_checks = 0;
    int             n_fail   = 0;
    bit             chk_en   = 1'b0;
    int             m_ptr    = 0;
    logic           m_wr_enb = 1'b0;
    logic           m_rd_enb = 1'b0;
    logic [AW-1:0]  m_wr_addr = '0;
    logic [DW-1:0]  m_wr_data = '0;
    logic [AW-1:0]  m_rd_addr = '0;
    logic [DW-1:0]  ref_mem [256];
    logic [SB_W-1:0] exp_q[$];

    function automatic logic [NR-1:0] model_gnt(input logic [NR-1:0] r, input int p);
        logic [NR-1:0] sh;
        logic [NR-1:0] one;
        one = 1;
        for (int k = 0; k < NR; k++) begin
            sh = r >> ((p + k) % NR);
            if (sh[0]) return one << ((p + k) % NR);
        end
        return '0;
    endfunction

    always @(negedge clk) begin
        logic [NR-1:0]   eg;
        logic [NR-1:0]   oh;
        logic [SB_W-1:0] e;
        logic [AW-1:0]   a;
        logic [DW-1:0]   d;
        logic [ID_WIDTH-1:0] ep;
        if (chk_en) begin
            eg = rst ? '0 : model_gnt(req, m_ptr);
            n_checks++;
            if (gnt !== eg) begin
                n_fail++;
                $display("FAIL gnt cyc=%0d actual=%b expected=%b", cyc, gnt, eg);
            end
            n_checks++;
            if ({wr_enb, rd_enb} !== {m_wr_enb, m_rd_enb}) begin
                n_fail++;
                $display("FAIL strobes cyc=%0d actual wr/rd=%b%b expected=%b%b", cyc, wr_enb, rd_enb, m_wr_enb, m_rd_enb);
            end
            n_checks++;
            if ({wr_addr, wr_data, rd_addr} !== {m_wr_addr, m_wr_data, m_rd_addr}) begin
                n_fail++;
                $display("FAIL ram_bus cyc=%0d actual wa=%h wd=%h ra=%h expected wa=%h wd=%h ra=%h",
                         cyc, wr_addr, wr_data, rd_addr, m_wr_addr, m_wr_data, m_rd_addr);
            end
            ep = ID_WIDTH'(m_ptr);
            n_checks++;
            if (dbg_rr_ptr !== ep) begin
                n_fail++;
                $display("FAIL rr_ptr cyc=%0d actual=%0d expected=%0d", cyc, dbg_rr_ptr, ep);
            end
            e = (exp_q.size() > 0) ? exp_q[0] : '0;
            if (rsp_valid !== '0 || (exp_q.size() > 0 && e[SB_W-1 -: 32] == cyc)) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_unexpected cyc=%0d actual valid=%b data=%h expected none", cyc, rsp_valid, rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    if (e[SB_W-1 -: 32] != cyc || rsp_valid !== e[DW +: NR] || rsp_data !== e[DW-1:0]) begin
                        n_fail++;
                        $display("FAIL rsp cyc=%0d actual valid=%b data=%h expected cyc=%0d valid=%b data=%h",
                                 cyc, rsp_valid, rsp_data, e[SB_W-1 -: 32], e[DW +: NR], e[DW-1:0]);
                    end
                end
            end
            if (rst) begin
                m_ptr = 0; m_wr_enb = 1'b0; m_rd_enb = 1'b0;
                m_wr_addr = '0; m_wr_data = '0; m_rd_addr = '0;
                exp_q.delete();
            end else begin
                m_wr_enb = 1'b0;
                m_rd_enb = 1'b0;
                for (int i = 0; i < NR; i++) begin
                    if (eg[i]) begin
                        a = req_addr[i*AW +: AW];
                        d = req_wdata[i*DW +: DW];
                        if (req_we[i]) begin
                            m_wr_enb = 1'b1; m_wr_addr = a; m_wr_data = d;
                            ref_mem[a] = d;
                        end else begin
                            m_rd_enb = 1'b1; m_rd_addr = a;
                            oh = '0; oh[i] = 1'b1;
                            exp_q.push_back({32'(cyc + 2 + RL), oh, ref_mem[a]});
                        end
                        m_ptr = (i + 1) % NR;
                    end
                end
            end
        end
    end

    // ---------------- scenario tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 2'b11; req_we = 2'b00; req_addr = {8'h05, 8'h04};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (gnt !== '0 || wr_enb !== 1'b0 || rd_enb !== 1'b0 || rsp_valid !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs k=%0d actual gnt=%b wr=%b rd=%b rsp=%b expected all 0", k, gnt, wr_enb, rd_enb, rsp_valid);
            end
            if (k == 0) begin
                n_checks++;
                if ({wr_addr, wr_data, rd_addr, rsp_data} !== '0) begin
                    n_fail++;
                    $display("FAIL reset_regs actual wa=%h wd=%h ra=%h rd=%h expected 0", wr_addr, wr_data, rd_addr, rsp_data);
                end
            end
            next_cycle();
        end
        rst = 1'b0; req = '0;
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] seq [4];
        logic [AW-1:0] ea;
        seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;
        req = 2'b11; req_we = 2'b11; req_addr = {8'h31, 8'h30}; req_wdata = {8'hC1, 8'hC0};
        for (int k = 0; k < 5; k++) begin
            if (k == 4) req = '0;
            @(negedge clk);
            if (k < 4) begin
                n_checks++;
                if (gnt !== seq[k]) begin
                    n_fail++;
                    $display("FAIL rr_gnt k=%0d actual=%b expected=%b", k, gnt, seq[k]);
                end
            end
            if (k > 0) begin
                ea = (k % 2 == 1) ? 8'h30 : 8'h31;
                n_checks++;
                if (wr_enb !== 1'b1 || wr_addr !== ea) begin
                    n_fail++;
                    $display("FAIL rr_wr_addr k=%0d actual en=%b addr=%h expected en=1 addr=%h", k, wr_enb, wr_addr, ea);
                end
            end
            next_cycle();
        end
        req_we = '0;
    endtask

    task automatic test_write_then_read();
        for (int k = 0; k < 6; k++) begin
            if (k == 0) begin
                req = 2'b01; req_we = 2'b01; req_addr[7:0] = 8'h10; req_wdata[7:0] = 8'hA5;
            end
            if (k == 1) req_we = 2'b00;
            if (k == 2) req = '0;
            @(negedge clk);
            if (k == 4) begin
                n_checks++;
                if (rsp_valid !== 2'b01 || rsp_data !== 8'hA5) begin
                    n_fail++;
                    $display("FAIL wr_rd_rsp actual valid=%b data=%h expected valid=01 data=a5", rsp_valid, rsp_data);
                end
            end
            if (k == 2 || k == 3) begin
                n_checks++;
                if (rsp_valid !== '0) begin
                    n_fail++;
                    $display("FAIL wr_rd_early k=%0d actual valid=%b expected 00", k, rsp_valid);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_interleaved_reads();
        for (int k = 0; k < 6; k++) begin
            if (k == 0) begin
                req = 2'b01; req_we = 2'b00; req_addr = {8'h02, 8'h01};
            end
            if (k == 1) req = 2'b10;
            if (k == 2) req = '0;
            @(negedge clk);
            if (k == 3) begin
                n_checks++;
                if (rsp_valid !== 2'b01 || rsp_data !== 8'h11) begin
                    n_fail++;
                    $display("FAIL ileave_rsp0 actual valid=%b data=%h expected valid=01 data=11", rsp_valid, rsp_data);
                end
            end
            if (k == 4) begin
                n_checks++;
                if (rsp_valid !== 2'b10 || rsp_data !== 8'h22) begin
                    n_fail++;
                    $display("FAIL ileave_rsp1 actual valid=%b data=%h expected valid=10 data=22", rsp_valid, rsp_data);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_read();
        for (int k = 0; k < 9; k++) begin
            if (k == 0) begin
                req = 2'b01; req_we = 2'b00; req_addr = {8'h05, 8'h03};
            end
            if (k == 1) begin
                req = '0; rst = 1'b1;
            end
            if (k == 2) begin
                rst = 1'b0; req = 2'b11; req_addr = {8'h05, 8'h04};
            end
            if (k == 5) req = '0;
            @(negedge clk);
            if (k >= 1 && k <= 4) begin
                n_checks++;
                if (rsp_valid !== '0) begin
                    n_fail++;
                    $display("FAIL mid_reset_rsp k=%0d actual valid=%b expected 00", k, rsp_valid);
                end
            end
            if (k == 2) begin
                n_checks++;
                if (gnt !== 2'b01 || dbg_rr_ptr !== '0) begin
                    n_fail++;
                    $display("FAIL mid_reset_gnt actual gnt=%b ptr=%0d expected gnt=01 ptr=0", gnt, dbg_rr_ptr);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_single_requester();
        req = 2'b10; req_we = 2'b10; req_addr[15:8] = 8'h40; req_wdata[15:8] = 8'h99;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) req = '0;
            @(negedge clk);
            if (k < 4) begin
                n_checks++;
                if (gnt !== 2'b10) begin
                    n_fail++;
                    $display("FAIL single_gnt k=%0d actual=%b expected=10", k, gnt);
                end
            end
            if (k > 0) begin
                n_checks++;
                if (dbg_rr_ptr !== '0) begin
                    n_fail++;
                    $display("FAIL single_ptr k=%0d actual=%0d expected=0", k, dbg_rr_ptr);
                end
            end
            next_cycle();
        end
        req_we = '0;
    endtask

    // Random traffic; each requester keeps its command stable until granted.
    task automatic test_back_to_back_random();
        logic [NR-1:0] last_gnt;
        last_gnt = '0;
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req[i] || last_gnt[i]) begin
                    req[i]    = 1'($urandom_range(0, 3) != 0);
                    req_we[i] = 1'($urandom_range(0, 1));
                    req_addr[i*AW +: AW]  = AW'($urandom_range(0, 15));
                    req_wdata[i*DW +: DW] = DW'($urandom_range(0, 255));
                end
            end
            @(negedge clk);
            last_gnt = gnt;
            next_cycle();
        end
        req = '0;
    endtask

    task automatic test_drain();
        req = '0;
        repeat (6) next_cycle();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain actual pending=%0d expected 0", exp_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     = DW'(i * 17);
            ref_mem[i] = DW'(i * 17);
        end
        rst = 1'b1;
        next_cycle();
        chk_en = 1'b1;
        test_reset();
        test_round_robin();
        test_write_then_read();
        test_interleaved_reads();
        test_reset_mid_read();
        test_single_requester();
        test_back_to_back_random();
        test_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
